// File: rtl/nmi_router_pkg.sv
// Shared types, constants and width helpers for the NMI address router.
package nmi_router_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request payload captured in IDLE and broadcast to every slave.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } nmi_req_t;

  function automatic int unsigned slv_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned tmo_cnt_w(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/nmi_addr_dec.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module nmi_addr_dec
  import nmi_router_pkg::*;
#(
  parameter int unsigned NUM_SLV = 5,
  localparam int unsigned SEL_W = slv_idx_w(NUM_SLV)
) (
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [NUM_SLV*ADDR_W-1:0] base_i,
  input  logic [NUM_SLV*ADDR_W-1:0] mask_i,
  output logic                      hit_o,
  output logic [SEL_W-1:0]          sel_idx_o
);

  // Walk from the top so that lower indices overwrite higher ones.
  always_comb begin
    hit_o     = 1'b0;
    sel_idx_o = '0;
    for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
      if ((addr_i & mask_i[ADDR_W*i +: ADDR_W]) ==
          (base_i[ADDR_W*i +: ADDR_W] & mask_i[ADDR_W*i +: ADDR_W])) begin
        hit_o     = 1'b1;
        sel_idx_o = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/nmi_router.sv
// Routes one NMI master to NUM_SLV NMI slaves, answering unmapped or hung
// accesses with ERR_RDATA and recording them in sticky error flags.
module nmi_router
  import nmi_router_pkg::*;
#(
  parameter int unsigned                  NUM_SLV    = 5,
  parameter logic [NUM_SLV*ADDR_W-1:0]    SLV_BASE   = {NUM_SLV{32'h0}},
  parameter logic [NUM_SLV*ADDR_W-1:0]    SLV_MASK   = {NUM_SLV{32'hFFFF_FFFF}},
  parameter int unsigned                  TMO_CYCLES = 1024,
  parameter logic [DATA_W-1:0]            ERR_RDATA  = ERR_RDATA_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          mst_valid_i,
  input  logic [ADDR_W-1:0]             mst_addr_i,
  input  logic [DATA_W-1:0]             mst_wdata_i,
  input  logic [STRB_W-1:0]             mst_wstrb_i,
  output logic [DATA_W-1:0]             mst_rdata_o,
  output logic                          mst_ready_o,
  output logic [NUM_SLV-1:0]            slv_valid_o,
  output logic [ADDR_W-1:0]             slv_addr_o,
  output logic [DATA_W-1:0]             slv_wdata_o,
  output logic [STRB_W-1:0]             slv_wstrb_o,
  input  logic [NUM_SLV*DATA_W-1:0]     slv_rdata_i,
  input  logic [NUM_SLV-1:0]            slv_ready_i,
  input  logic                          err_clr_i,
  output logic                          err_dec_o,
  output logic                          err_tmo_o,
  output logic [ADDR_W-1:0]             err_addr_o
);

  localparam int unsigned      SEL_W    = slv_idx_w(NUM_SLV);
  localparam int unsigned      CNT_W    = tmo_cnt_w(TMO_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);
  localparam bit               TMO_EN   = (TMO_CYCLES != 0);

  state_e               state_q, state_d;
  nmi_req_t             req_q, req_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SLV-1:0]   slv_valid_q, slv_valid_d;
  logic                 mst_ready_q, mst_ready_d;
  logic [DATA_W-1:0]    mst_rdata_q, mst_rdata_d;
  logic                 err_dec_q, err_dec_d;
  logic                 err_tmo_q, err_tmo_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;

  logic                 dec_hit;
  logic [SEL_W-1:0]     dec_sel;
  logic [DATA_W-1:0]    sel_rdata;
  logic                 sel_ready;

  nmi_addr_dec #(
    .NUM_SLV (NUM_SLV)
  ) u_dec (
    .addr_i    (mst_addr_i),
    .base_i    (SLV_BASE),
    .mask_i    (SLV_MASK),
    .hit_o     (dec_hit),
    .sel_idx_o (dec_sel)
  );

  // Response mux for the slave latched in IDLE; other slaves' ready is ignored.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_rdata = slv_rdata_i[DATA_W*i +: DATA_W];
        sel_ready = slv_ready_i[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky flags clear on err_clr_i, but a same-cycle new error still sets them.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    slv_valid_d = '0;
    mst_ready_d = 1'b0;
    mst_rdata_d = mst_rdata_q;
    err_dec_d   = err_dec_q & ~err_clr_i;
    err_tmo_d   = err_tmo_q & ~err_clr_i;
    err_addr_d  = err_addr_q;

    unique case (state_q)
      IDLE: begin
        if (mst_valid_i) begin
          req_d.addr  = mst_addr_i;
          req_d.wdata = mst_wdata_i;
          req_d.wstrb = mst_wstrb_i;
          sel_d       = dec_sel;
          cnt_d       = '0;
          if (dec_hit) begin
            state_d     = BUSY;
            slv_valid_d = NUM_SLV'(1) << dec_sel;
          end else begin
            state_d     = RESP;
            mst_ready_d = 1'b1;
            mst_rdata_d = ERR_RDATA;
            err_dec_d   = 1'b1;
            err_addr_d  = mst_addr_i;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sel_ready) begin
          state_d     = RESP;
          mst_ready_d = 1'b1;
          mst_rdata_d = sel_rdata;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          state_d     = RESP;
          mst_ready_d = 1'b1;
          mst_rdata_d = ERR_RDATA;
          err_tmo_d   = 1'b1;
          err_addr_d  = req_q.addr;
        end else begin
          slv_valid_d = slv_valid_q;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      slv_valid_q <= '0;
      mst_ready_q <= 1'b0;
      mst_rdata_q <= '0;
      err_dec_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      req_q       <= req_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      slv_valid_q <= slv_valid_d;
      mst_ready_q <= mst_ready_d;
      mst_rdata_q <= mst_rdata_d;
      err_dec_q   <= err_dec_d;
      err_tmo_q   <= err_tmo_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign mst_rdata_o = mst_rdata_q;
  assign mst_ready_o = mst_ready_q;
  assign slv_valid_o = slv_valid_q;
  assign slv_addr_o  = req_q.addr;
  assign slv_wdata_o = req_q.wdata;
  assign slv_wstrb_o = req_q.wstrb;
  assign err_dec_o   = err_dec_q;
  assign err_tmo_o   = err_tmo_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_nmi_router.sv
// Bench for nmi_router: directed scenarios plus randomized transactions
// checked against a transaction-level model of the address map and timeout.
module tb_nmi_router;

  localparam int NS  = 3;
  localparam int TMO = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  // slave 2 (exact 0x0300_0000) is shadowed by slave 0
  localparam logic [NS*32-1:0] BASE = {32'h0300_0000, 32'h0400_0000, 32'h0300_0000};
  localparam logic [NS*32-1:0] MASK = {32'hFFFF_FFFF, 32'hFF00_0000, 32'hFF00_0000};

  logic [31:0] m_base [NS] = '{32'h0300_0000, 32'h0400_0000, 32'h0300_0000};
  logic [31:0] m_mask [NS] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFFFF_FFFF};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mst_valid = 1'b0;
  logic [31:0]       mst_addr = '0;
  logic [31:0]       mst_wdata = '0;
  logic [3:0]        mst_wstrb = '0;
  logic [31:0]       mst_rdata;
  logic              mst_ready;
  logic [NS-1:0]     slv_valid;
  logic [31:0]       slv_addr;
  logic [31:0]       slv_wdata;
  logic [3:0]        slv_wstrb;
  logic [NS*32-1:0]  slv_rdata = '0;
  logic [NS-1:0]     slv_ready = '0;
  logic              err_clr = 1'b0;
  logic              err_dec;
  logic              err_tmo;
  logic [31:0]       err_addr;

  int n_checks = 0;
  int n_fail = 0;

  logic        exp_dec = 1'b0;
  logic        exp_tmo = 1'b0;
  logic [31:0] exp_eaddr = '0;

  nmi_router #(
    .NUM_SLV    (NS),
    .SLV_BASE   (BASE),
    .SLV_MASK   (MASK),
    .TMO_CYCLES (TMO),
    .ERR_RDATA  (ERRD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mst_valid_i (mst_valid),
    .mst_addr_i  (mst_addr),
    .mst_wdata_i (mst_wdata),
    .mst_wstrb_i (mst_wstrb),
    .mst_rdata_o (mst_rdata),
    .mst_ready_o (mst_ready),
    .slv_valid_o (slv_valid),
    .slv_addr_o  (slv_addr),
    .slv_wdata_o (slv_wdata),
    .slv_wstrb_o (slv_wstrb),
    .slv_rdata_i (slv_rdata),
    .slv_ready_i (slv_ready),
    .err_clr_i   (err_clr),
    .err_dec_o   (err_dec),
    .err_tmo_o   (err_tmo),
    .err_addr_o  (err_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Address-map model: first slave whose masked base matches, -1 if none.
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & m_mask[i]) == (m_base[i] & m_mask[i])) return i;
    return -1;
  endfunction

  // Behavioural master + slaves: one request, slave idx answers on busy cycle dly+1.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                         input int idx, input int dly, input logic [31:0] rd, input logic clr0,
                         output int lat, output logic [31:0] rdo, output int busy,
                         output logic [NS-1:0] vseen, output logic [31:0] aseen,
                         output logic [31:0] wseen, output logic [3:0] sseen,
                         output int pulses, output logic [31:0] hold);
    lat = -1; rdo = '0; busy = 0; vseen = '0; aseen = '0; wseen = '0; sseen = '0;
    pulses = 0; hold = '0;
    @(negedge clk);
    mst_valid = 1'b1; mst_addr = a; mst_wdata = wd; mst_wstrb = s; err_clr = clr0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      err_clr = 1'b0;
      slv_ready = '0;
      for (int i = 0; i < NS; i++) slv_rdata[32*i +: 32] = $urandom;
      if (slv_valid != '0) begin
        busy++;
        vseen |= slv_valid; aseen = slv_addr; wseen = slv_wdata; sseen = slv_wstrb;
        if (idx >= 0) begin
          slv_ready = NS'($urandom) & ~(NS'(1) << idx);
          slv_rdata[32*idx +: 32] = rd;
          if (busy == dly + 1) slv_ready[idx] = 1'b1;
        end
      end
      if (mst_ready) begin
        lat = c; rdo = mst_rdata; pulses++; mst_valid = 1'b0;
      end
    end
    mst_valid = 1'b0; slv_ready = '0;
    @(negedge clk);
    if (mst_ready) pulses++;
    hold = mst_rdata;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mst_ready, slv_valid, err_dec, err_tmo} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0", {mst_ready, slv_valid, err_dec, err_tmo});
    end
    n_checks++;
    if ({mst_rdata, err_addr, slv_addr, slv_wdata, slv_wstrb} !== '0) begin
      n_fail++; $display("FAIL reset_data: got rdata=%h eaddr=%h addr=%h required 0", mst_rdata, err_addr, slv_addr);
    end
    rst = 1'b0;
    exp_dec = 0; exp_tmo = 0; exp_eaddr = '0;
  endtask

  task automatic test_write;
    int lat, busy, pulses; logic [31:0] rdo, as, ws, hold; logic [NS-1:0] vs; logic [3:0] ss;
    run_txn(32'h0300_0010, 4'hF, 32'h1234_5678, ref_decode(32'h0300_0010), 3, 32'h0, 1'b0,
            lat, rdo, busy, vs, as, ws, ss, pulses, hold);
    n_checks++;
    if (vs !== 3'b001) begin n_fail++; $display("FAIL write_valid: got %b required 001", vs); end
    n_checks++;
    if ({as, ws, ss} !== {32'h0300_0010, 32'h1234_5678, 4'hF}) begin
      n_fail++; $display("FAIL write_bcast: got %h/%h/%h required 03000010/12345678/f", as, ws, ss);
    end
    n_checks++;
    if (pulses !== 1 || lat !== 5 || busy !== 4) begin
      n_fail++; $display("FAIL write_timing: got pulses=%0d lat=%0d busy=%0d required 1/5/4", pulses, lat, busy);
    end
    n_checks++;
    if ({err_dec, err_tmo} !== 2'b00) begin
      n_fail++; $display("FAIL write_err: got %b required 00", {err_dec, err_tmo});
    end
  endtask

  task automatic test_read_comb;
    int lat, busy, pulses; logic [31:0] rdo, as, ws, hold; logic [NS-1:0] vs; logic [3:0] ss;
    run_txn(32'h0400_0004, 4'h0, 32'h0, ref_decode(32'h0400_0004), 0, 32'hCAFE_0001, 1'b0,
            lat, rdo, busy, vs, as, ws, ss, pulses, hold);
    n_checks++;
    if (rdo !== 32'hCAFE_0001 || hold !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL read_data: got %h hold %h required cafe0001", rdo, hold);
    end
    n_checks++;
    if (lat !== 2 || vs !== 3'b010) begin
      n_fail++; $display("FAIL read_lat: got lat=%0d valid=%b required 2/010", lat, vs);
    end
  endtask

  task automatic test_decode_err;
    int lat, busy, pulses; logic [31:0] rdo, as, ws, hold; logic [NS-1:0] vs; logic [3:0] ss;
    run_txn(32'h0900_0000, 4'h0, 32'h0, ref_decode(32'h0900_0000), 0, 32'h0, 1'b0,
            lat, rdo, busy, vs, as, ws, ss, pulses, hold);
    n_checks++;
    if (lat !== 1 || busy !== 0 || rdo !== ERRD) begin
      n_fail++; $display("FAIL dec_resp: got lat=%0d busy=%0d rdata=%h required 1/0/deadbeef", lat, busy, rdo);
    end
    n_checks++;
    if (err_dec !== 1'b1 || err_addr !== 32'h0900_0000) begin
      n_fail++; $display("FAIL dec_flag: got dec=%b addr=%h required 1/09000000", err_dec, err_addr);
    end
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    n_checks++;
    if (err_dec !== 1'b0 || err_addr !== 32'h0900_0000) begin
      n_fail++; $display("FAIL dec_clear: got dec=%b addr=%h required 0/09000000", err_dec, err_addr);
    end
    // clear in the same cycle as a fresh decode error: set must win
    run_txn(32'h0A00_0000, 4'h0, 32'h0, ref_decode(32'h0A00_0000), 0, 32'h0, 1'b1,
            lat, rdo, busy, vs, as, ws, ss, pulses, hold);
    n_checks++;
    if (err_dec !== 1'b1 || err_addr !== 32'h0A00_0000) begin
      n_fail++; $display("FAIL dec_setwins: got dec=%b addr=%h required 1/0a000000", err_dec, err_addr);
    end
    exp_dec = 1; exp_tmo = 0; exp_eaddr = 32'h0A00_0000;
  endtask

  task automatic test_timeout;
    int lat, busy, pulses; logic [31:0] rdo, as, ws, hold; logic [NS-1:0] vs; logic [3:0] ss;
    run_txn(32'h0400_0100, 4'h0, 32'h0, ref_decode(32'h0400_0100), 1000, 32'h0, 1'b0,
            lat, rdo, busy, vs, as, ws, ss, pulses, hold);
    n_checks++;
    if (busy !== TMO || lat !== TMO + 1 || rdo !== ERRD) begin
      n_fail++; $display("FAIL tmo_resp: got busy=%0d lat=%0d rdata=%h required 16/17/deadbeef", busy, lat, rdo);
    end
    n_checks++;
    if (err_tmo !== 1'b1 || err_addr !== 32'h0400_0100) begin
      n_fail++; $display("FAIL tmo_flag: got tmo=%b addr=%h required 1/04000100", err_tmo, err_addr);
    end
    // ready on the last allowed busy cycle beats the timeout; flags cleared at start
    run_txn(32'h0400_0200, 4'h0, 32'h0, ref_decode(32'h0400_0200), TMO - 1, 32'h5A5A_0016, 1'b1,
            lat, rdo, busy, vs, as, ws, ss, pulses, hold);
    n_checks++;
    if (busy !== TMO || lat !== TMO + 1 || rdo !== 32'h5A5A_0016) begin
      n_fail++; $display("FAIL tmo_edge: got busy=%0d lat=%0d rdata=%h required 16/17/5a5a0016", busy, lat, rdo);
    end
    n_checks++;
    if ({err_dec, err_tmo} !== 2'b00 || err_addr !== 32'h0400_0100) begin
      n_fail++; $display("FAIL tmo_edge_err: got %b addr=%h required 00/04000100", {err_dec, err_tmo}, err_addr);
    end
    exp_dec = 0; exp_tmo = 0; exp_eaddr = 32'h0400_0100;
  endtask

  task automatic test_overlap;
    int lat, busy, pulses; logic [31:0] rdo, as, ws, hold; logic [NS-1:0] vs; logic [3:0] ss;
    run_txn(32'h0300_0000, 4'h0, 32'h0, 0, 1, 32'h0000_0ABC, 1'b0,
            lat, rdo, busy, vs, as, ws, ss, pulses, hold);
    n_checks++;
    if (vs !== 3'b001 || rdo !== 32'h0000_0ABC) begin
      n_fail++; $display("FAIL overlap: got valid=%b rdata=%h required 001/00000abc", vs, rdo);
    end
  endtask

  task automatic test_reset_busy;
    int seen;
    @(negedge clk);
    mst_valid = 1'b1; mst_addr = 32'h0400_0008; mst_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (slv_valid !== 3'b010) begin n_fail++; $display("FAIL rstbusy_pre: got %b required 010", slv_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mst_valid = 1'b0;
    n_checks++;
    if ({slv_valid, mst_ready, err_dec, err_tmo} !== '0 || err_addr !== '0) begin
      n_fail++; $display("FAIL rstbusy_out: got valid=%b ready=%b eaddr=%h required 0", slv_valid, mst_ready, err_addr);
    end
    exp_dec = 0; exp_tmo = 0; exp_eaddr = '0;
    seen = 0;
    slv_ready = '1;
    repeat (4) begin
      @(negedge clk);
      if (mst_ready || slv_valid != '0) seen++;
    end
    slv_ready = '0;
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rstbusy_late: got %0d responses required 0", seen); end
  endtask

  task automatic test_random;
    int lat, busy, pulses, idx, dly, elat, ebusy; logic [31:0] rdo, as, ws, hold, a, wd, rd, erd;
    logic [NS-1:0] vs, evs; logic [3:0] ss, s; logic clr0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: a = {8'h03, 24'($urandom)};
        1: a = {8'h04, 24'($urandom)};
        2: a = 32'h0300_0000;
        3: a = {8'($urandom_range(5, 255)), 24'($urandom)};
        default: a = {8'($urandom_range(0, 2)), 24'($urandom)};
      endcase
      dly = $urandom_range(0, 20); rd = $urandom; wd = $urandom; s = 4'($urandom);
      clr0 = ($urandom_range(0, 3) == 0);
      idx = ref_decode(a);
      if (clr0) begin exp_dec = 0; exp_tmo = 0; end
      if (idx < 0) begin
        elat = 1; ebusy = 0; erd = ERRD; exp_dec = 1; exp_eaddr = a;
      end else if (dly < TMO) begin
        elat = dly + 2; ebusy = dly + 1; erd = rd;
      end else begin
        elat = TMO + 1; ebusy = TMO; erd = ERRD; exp_tmo = 1; exp_eaddr = a;
      end
      evs = (idx < 0) ? '0 : NS'(1) << idx;
      run_txn(a, s, wd, idx, dly, rd, clr0, lat, rdo, busy, vs, as, ws, ss, pulses, hold);
      n_checks++;
      if (lat !== elat || busy !== ebusy || pulses !== 1) begin
        n_fail++; $display("FAIL rnd%0d_timing: addr=%h got lat=%0d busy=%0d pulses=%0d required %0d/%0d/1",
                           n, a, lat, busy, pulses, elat, ebusy);
      end
      n_checks++;
      if (rdo !== erd || hold !== erd) begin
        n_fail++; $display("FAIL rnd%0d_rdata: addr=%h got %h hold %h required %h", n, a, rdo, hold, erd);
      end
      n_checks++;
      if (vs !== evs || (idx >= 0 && {as, ws, ss} !== {a, wd, s})) begin
        n_fail++; $display("FAIL rnd%0d_slave: got valid=%b addr=%h required %b/%h", n, vs, as, evs, a);
      end
      n_checks++;
      if ({err_dec, err_tmo} !== {exp_dec, exp_tmo} || err_addr !== exp_eaddr) begin
        n_fail++; $display("FAIL rnd%0d_err: got %b addr=%h required %b/%h",
                           n, {err_dec, err_tmo}, err_addr, {exp_dec, exp_tmo}, exp_eaddr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_comb();
    test_decode_err();
    test_timeout();
    test_overlap();
    test_reset_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nmi_router.md
Name: nmi_router

Overview:
- Parametrised successor to the fixed native-memory-interface (NMI) address router between the core and its targets (natv, mmap, psram, spisd, i2s).
- One NMI master is routed to NUM_SLV NMI slaves through a parameter-defined address map.
- Adds decode-error and timeout responses with sticky error status, so a hung or unmapped access no longer stalls the core forever.
- Sits between core_wrapper and the peripheral wrappers.

Parameters:
- NUM_SLV, 5, number of slave ports (1..16).
- SLV_BASE, {NUM_SLV{32'h0}}, packed NUM_SLV*32 base addresses; slave i occupies [32*i +: 32].
- SLV_MASK, {NUM_SLV{32'hFFFF_FFFF}}, packed NUM_SLV*32 match masks; slave i hits when (addr & mask_i) == (base_i & mask_i).
- TMO_CYCLES, 1024, cycles in BUSY before timeout; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on a decode error or timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mst_valid_i  in  1  master request; held high until mst_ready_o
- mst_addr_i  in  32  master byte address
- mst_wdata_i  in  32  master write data
- mst_wstrb_i  in  4  byte strobes; 0 = read
- mst_rdata_o  out  32  response data
- mst_ready_o  out  1  one-cycle completion pulse
- slv_valid_o  out  NUM_SLV  one-hot per-slave valid
- slv_addr_o  out  32  registered address, broadcast to all slaves
- slv_wdata_o  out  32  registered write data, broadcast
- slv_wstrb_o  out  4  registered strobes, broadcast
- slv_rdata_i  in  NUM_SLV*32  slave read data; slave i at [32*i +: 32]
- slv_ready_i  in  NUM_SLV  slave completion
- err_clr_i  in  1  clears the sticky error flags
- err_dec_o  out  1  sticky: a decode error occurred
- err_tmo_o  out  1  sticky: a timeout occurred
- err_addr_o  out  32  address of the most recent error

Behaviour:
- Reset (rst_i high at a clk_i edge):
  - State goes to IDLE.
  - All outputs go to 0, except mst_rdata_o = 0 and err_addr_o = 0.
  - The timeout counter clears.
  - A slave ready arriving after reset is ignored.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On mst_valid_i, register addr/wdata/wstrb and the decode result.
  - Decode hit: go to BUSY with the selected index.
  - No slave matches: go to RESP with rdata = ERR_RDATA, set err_dec_o, capture err_addr_o.
- BUSY:
  - slv_valid_o[sel] = 1; all other bits are 0.
  - Counter increments each cycle.
  - slv_ready_i[sel] = 1: latch slv_rdata_i[sel] into mst_rdata_o, go to RESP.
  - Ready bits of unselected slaves are ignored.
  - Counter reaches TMO_CYCLES-1 without ready: go to RESP with ERR_RDATA, set err_tmo_o, capture err_addr_o.
  - Ready and timeout in the same cycle: ready wins, no error.
- RESP:
  - mst_ready_o = 1 for exactly one cycle; slv_valid_o = 0.
  - Next state is IDLE.
  - The master must drop valid after the ready pulse; IDLE only accepts a new request on the cycle after RESP.
- Latency:
  - Hit with a combinational slave ready: mst_ready_o asserts 2 cycles after mst_valid_i is first sampled in IDLE.
  - Decode error: 1 cycle.
- Decode priority: when the address map overlaps, the lowest slave index wins.
- Sticky flags:
  - err_clr_i clears err_dec_o/err_tmo_o one cycle later; err_addr_o is retained.
  - A new error coinciding with err_clr_i: set wins.
- mst_rdata_o holds its last value outside RESP.
- Width rules:
  - Counter width is $clog2(TMO_CYCLES+1), minimum 1.
  - Selected-index width is $clog2(NUM_SLV), minimum 1.

Decomposition:
- Package nmi_router_pkg: state enum (IDLE/BUSY/RESP), default ERR_RDATA constant, and helper function slv_idx_w(n).
- Sub-module nmi_addr_dec: combinational priority decoder.
  - Inputs: addr, SLV_BASE, SLV_MASK.
  - Outputs: hit, sel_idx.
  - Instantiated once.

Test Plan:
- Map: slave 0 = 0x0300_0000 / mask 0xFF00_0000; slave 1 = 0x0400_0000 / mask 0xFF00_0000. Write 0x0300_0010 with wstrb=0xF, data 0x1234_5678, slave 0 ready 3 cycles later:
  - slv_valid_o = 2'b01 with addr/wdata broadcast.
  - mst_ready_o pulses once; no errors.
- Read 0x0400_0004 with slave 1 returning 0xCAFE_0001 and a combinational ready: mst_rdata_o = 0xCAFE_0001, with mst_ready_o 2 cycles after valid.
- Access 0x0900_0000 (unmapped): mst_ready_o after 1 cycle, rdata 0xDEAD_BEEF, err_dec_o = 1, err_addr_o = 0x0900_0000. Then err_clr_i: flag clears, address retained.
- TMO_CYCLES = 16, slave 0 never ready: slv_valid_o drops after 16 BUSY cycles, rdata 0xDEAD_BEEF, err_tmo_o = 1. Repeat with ready arriving on cycle 16: normal response, no timeout.
- Overlapping map (slave 0 mask 0xF000_0000, slave 1 exact 0x0300_0000): access 0x0300_0000 selects slave 0.
- Assert rst_i while in BUSY: next cycle all slv_valid_o = 0 and state IDLE. A late slave ready produces no mst_ready_o.
